sfu_accbuf: RTL
===============

SFU_ACCBUF -- requirements
Module: sfu_accbuf

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- PSUM_BW, 16, signed partial-sum width per column.
- COL, 8, number of columns.
- DEPTH, 16, accumulator entries per column; power of two, at least 2.
- AW, $clog2(DEPTH), address width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock.
- reset, in, 1, asynchronous active-low reset.
- flush, in, 1, synchronous clear of all entry-valid bits and of sat.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, input beat accepted when in_valid and in_ready are both high.
- in_psum, in, PSUM_BW*COL, column i occupies [PSUM_BW*(i+1)-1 : PSUM_BW*i].
- in_addr, in, AW, accumulator entry to update.
- in_mode, in, 2, 00 bypass, 01 accumulate, 10 accumulate+ReLU, 11 signed max.
- in_last, in, 1, final beat for in_addr; causes a result to be emitted.
- out_valid, out, 1, result valid.
- out_ready, in, 1, result consumed when out_valid and out_ready are both high.
- out_data, out, PSUM_BW*COL, result, same column packing as in_psum.
- out_addr, out, AW, entry the result came from.
- sat, out, 1, sticky saturation flag.
- busy, out, 1, high when any entry-valid bit is set or out_valid is high.

Function
REQ-003 Storage SHALL be a DEPTH x COL array of PSUM_BW-bit signed accumulators plus one valid bit per entry.
REQ-004 in_ready SHALL equal (!out_valid || out_ready) && !flush.
REQ-005 Accepted bypass beat: out_data SHALL be loaded with in_psum and out_addr with in_addr on the next edge; out_valid SHALL be set; accumulator and valid bits SHALL be unchanged; in_last SHALL be ignored.
REQ-006 Accepted non-bypass beat, entry invalid: the entry SHALL be loaded with in_psum and its valid bit set.
REQ-007 Accepted non-bypass beat, entry valid, modes 01/10: each column SHALL be updated to acc + in, saturating at the signed PSUM_BW limits.
REQ-008 Accepted non-bypass beat, entry valid, mode 11: each column SHALL be updated to the signed max of acc and in.
REQ-009 Any column saturating SHALL set sat on the following edge; sat SHALL hold until flush or reset.
REQ-010 Accepted non-bypass beat with in_last high: the updated value (including the current beat) SHALL be registered into out_data, with out_addr = in_addr and out_valid = 1, on the same edge. The entry's valid bit SHALL be cleared on that edge.
REQ-011 Mode 10 emit: each negative column SHALL be output as 0. The stored value is not retained after emit, so ReLU affects only the output.
REQ-012 Latency SHALL be 1 cycle from acceptance to out_valid. Back-to-back beats to the same address SHALL see the prior update, with no bubble.
REQ-013 out_valid SHALL clear on an edge with out_ready high and no new emitting beat. It SHALL stay set, with out_data and out_addr stable, while out_ready is low.
REQ-014 A simultaneous drain and accepted emitting beat SHALL reload the output register with out_valid remaining high.
REQ-015 Mode SHALL be sampled per beat. Mixing modes on one entry is legal; each beat uses its own mode's arithmetic.
REQ-016 flush high SHALL clear all valid bits and sat on the edge. It SHALL NOT affect out_valid, out_data or out_addr.
REQ-017 Address wrap SHALL NOT exist. in_addr selects the entry directly, and every address in 0..DEPTH-1 is legal.

Reset
REQ-018 reset low SHALL asynchronously clear out_valid, out_data, out_addr, sat and all valid bits to 0. Accumulator data SHALL be don't-care.
REQ-019 Reset asserted mid-accumulation SHALL discard partial sums. After release, the first beat to any entry SHALL load (REQ-006).
REQ-020 in_ready SHALL be 0 while reset is low.

Verification
REQ-021 Mode 01, addr 3, beats 5, 7, -2 with last on the third -> one cycle later out_valid=1, out_addr=3, every column 10; entry 3 becomes invalid.
REQ-022 Mode 01, addr 0, beats 32000 then 1000 with last -> out column 32767 and sat=1; sat remains 1 until flush.
REQ-023 Mode 10, beats -9 then 4 with last -> out column 0. Mode 11, beats -9, 4, 2 with last -> out column 4.
REQ-024 out_ready held low 5 cycles with a result pending -> in_ready=0 and out_data stable; out_ready=1 with an emitting beat on the same edge -> new result, out_valid stays 1.
REQ-025 Addr 1 partial sum 6 (no last), flush pulse, then beat 2 with last -> out column 2. Separately, reset pulse mid-accumulation then beat 3 with last -> out column 3.
REQ-026 Bypass beat 0x1234 per column while entry 2 holds a partial sum -> out_data = 0x1234 next cycle; a later beat to entry 2 with last still includes the partial sum.

Source files
------------

// File: rtl/sfu_accbuf.sv
// Per-column partial-sum accumulator buffer: accumulate, ReLU and signed-max
// reduction per entry, with a one-deep output register emitted on the last beat.
module sfu_accbuf #(
    parameter int unsigned PSUM_BW = 16,
    parameter int unsigned COL     = 8,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned AW      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PSUM_BW*COL-1:0] in_psum,
    input  logic [AW-1:0]          in_addr,
    input  logic [1:0]             in_mode,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PSUM_BW*COL-1:0] out_data,
    output logic [AW-1:0]          out_addr,
    output logic                   sat,
    output logic                   busy
);

    localparam int unsigned DW = PSUM_BW * COL;
    localparam logic [1:0] MODE_BYP  = 2'b00;
    localparam logic [1:0] MODE_RELU = 2'b10;
    localparam logic [1:0] MODE_MAX  = 2'b11;
    localparam logic [PSUM_BW-1:0] SMAX = {1'b0, {(PSUM_BW-1){1'b1}}};
    localparam logic [PSUM_BW-1:0] SMIN = {1'b1, {(PSUM_BW-1){1'b0}}};

    logic [DW-1:0]      acc_q [DEPTH];
    logic [DEPTH-1:0]   vld_q, vld_d;
    logic               sat_q, sat_d;
    logic               ov_q, ov_d;
    logic [DW-1:0]      od_q, od_d;
    logic [AW-1:0]      oa_q, oa_d;

    logic               accept;
    logic               is_acc;
    logic [DW-1:0]      upd_c;
    logic [DW-1:0]      relu_c;
    logic               ovf_c;
    logic [PSUM_BW-1:0] col_a, col_b, col_r;
    logic [PSUM_BW:0]   col_sum;

    // Reset gating keeps the input stalled while the block is held in reset.
    assign in_ready  = reset && (!ov_q || out_ready) && !flush;
    assign accept    = in_valid && in_ready;
    assign is_acc    = accept && (in_mode != MODE_BYP);
    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign out_addr  = oa_q;
    assign sat       = sat_q;
    assign busy      = (|vld_q) || ov_q;

    // Per-column update of the addressed entry; an invalid entry simply loads the beat.
    always_comb begin
        upd_c   = '0;
        relu_c  = '0;
        ovf_c   = 1'b0;
        col_a   = '0;
        col_b   = '0;
        col_r   = '0;
        col_sum = '0;
        for (int c = 0; c < COL; c++) begin
            col_a   = acc_q[in_addr][c*PSUM_BW +: PSUM_BW];
            col_b   = in_psum[c*PSUM_BW +: PSUM_BW];
            col_sum = {col_a[PSUM_BW-1], col_a} + {col_b[PSUM_BW-1], col_b};
            col_r   = col_b;
            if (vld_q[in_addr]) begin
                if (in_mode == MODE_MAX) begin
                    col_r = ($signed(col_a) > $signed(col_b)) ? col_a : col_b;
                end else if (col_sum[PSUM_BW] != col_sum[PSUM_BW-1]) begin
                    col_r = col_sum[PSUM_BW] ? SMIN : SMAX;
                    ovf_c = 1'b1;
                end else begin
                    col_r = col_sum[PSUM_BW-1:0];
                end
            end
            upd_c[c*PSUM_BW +: PSUM_BW]  = col_r;
            relu_c[c*PSUM_BW +: PSUM_BW] = ((in_mode == MODE_RELU) && col_r[PSUM_BW-1]) ? '0 : col_r;
        end
    end

    // Next state for entry-valid bits, sticky saturation and the output register.
    always_comb begin
        vld_d = vld_q;
        sat_d = sat_q;
        ov_d  = ov_q;
        od_d  = od_q;
        oa_d  = oa_q;
        if (flush) begin
            vld_d = '0;
            sat_d = 1'b0;
        end else if (is_acc) begin
            vld_d[in_addr] = !in_last;
            if (ovf_c) begin
                sat_d = 1'b1;
            end
        end
        if (accept && (in_mode == MODE_BYP)) begin
            ov_d = 1'b1;
            od_d = in_psum;
            oa_d = in_addr;
        end else if (is_acc && in_last) begin
            ov_d = 1'b1;
            od_d = relu_c;
            oa_d = in_addr;
        end else if (out_ready) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            sat_q <= 1'b0;
            ov_q  <= 1'b0;
            od_q  <= '0;
            oa_q  <= '0;
        end else begin
            vld_q <= vld_d;
            sat_q <= sat_d;
            ov_q  <= ov_d;
            od_q  <= od_d;
            oa_q  <= oa_d;
        end
    end

    // Accumulator contents need no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (is_acc) begin
            acc_q[in_addr] <= upd_c;
        end
    end

endmodule
